// File: rtl/store_align_unit.sv
// -----------------------------------------------------------------------------
// store_align_unit
//
// Write-side MEM-stage datapath. Takes one store request (width code, byte
// address, LSB-justified data), positions the data onto the byte lanes of a
// 64-bit memory word, builds the byte write mask, and drives one write beat
// at a time toward data memory. A store that crosses an 8-byte boundary is
// either split into two aligned beats or rejected, depending on the build.
//
// Build option:
//   MISALIGN_SPLIT_EN  defined     -> boundary-crossing stores are split into
//                                     two beats (BEAT0 then BEAT1).
//                      not defined -> boundary-crossing stores are rejected
//                                     with st_err; only one beat ever issued.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   st_valid/st_ready request handshake (ready only while idle)
//   st_width          width code: 001 double, 010 word, 011 half, 100 byte;
//                     000 and 101..111 are illegal for a store
//   st_addr, st_data  byte address and LSB-justified store data
//   mem_wen           write beat valid, held until mem_ack
//   mem_addr          8-byte-aligned beat address
//   mem_wdata         lane-positioned beat data, unused lanes zero
//   mem_wmask         byte enables, bit i covers mem_wdata[8i+7:8i]
//   mem_ack           memory accepts the current beat
//   st_done, st_err   one-cycle completion / rejection pulses
//   dbg_state         current FSM state (0 idle, 1 beat0, 2 beat1)
//
// Handshakes: a request transfers on a rising edge where st_valid and
// st_ready are both high; a beat transfers on a rising edge where mem_wen and
// mem_ack are both high. mem_addr/mem_wdata/mem_wmask do not change while
// mem_wen is high and mem_ack is low; mem_ack with mem_wen low is ignored.
// -----------------------------------------------------------------------------
module store_align_unit #(
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [2:0]        st_width,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [63:0]       st_data,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [63:0]       mem_wdata,
  output logic [7:0]        mem_wmask,
  input  logic              mem_ack,
  output logic              st_done,
  output logic              st_err,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BEAT0 = 2'd1
`ifdef MISALIGN_SPLIT_EN
    ,
    S_BEAT1 = 2'd2
`endif
  } state_t;

  state_t state, state_d;

  // ---------------------------------------------------------------------------
  // Request decode and lane placement (combinational, used only on accept)
  // ---------------------------------------------------------------------------
  logic              accept;
  logic              legal;
  logic [7:0]        lane_en;   // bytes of st_data that belong to the store
  logic [2:0]        off;
  logic [63:0]       trunc;
  logic [15:0]       span;      // byte mask across two consecutive words
  logic [ADDR_W-1:0] base;
  logic [7:0]        mask0;
  logic [63:0]       data0;
  logic              reject;

  assign accept = st_valid && (state == S_IDLE);
  assign off    = st_addr[2:0];
  assign base   = {st_addr[ADDR_W-1:3], 3'b000};

  always_comb begin
    legal   = 1'b0;
    lane_en = 8'h00;
    case (st_width)
      3'b001: begin legal = 1'b1; lane_en = 8'hFF; end
      3'b010: begin legal = 1'b1; lane_en = 8'h0F; end
      3'b011: begin legal = 1'b1; lane_en = 8'h03; end
      3'b100: begin legal = 1'b1; lane_en = 8'h01; end
      default: begin legal = 1'b0; lane_en = 8'h00; end
    endcase
  end

  // Drop the bytes above the store size so they never reach memory.
  always_comb begin
    trunc = 64'h0;
    for (int i = 0; i < 8; i++) begin
      trunc[8*i +: 8] = lane_en[i] ? st_data[8*i +: 8] : 8'h00;
    end
  end

  assign span  = {8'h00, lane_en} << off;
  assign mask0 = span[7:0];

`ifdef MISALIGN_SPLIT_EN
  logic [127:0]      data_full;
  logic [ADDR_W-1:0] b1_addr;
  logic [63:0]       b1_wdata;
  logic [7:0]        b1_wmask;
  logic              b1_pend;
  logic              load_b1;

  assign data_full = {64'h0, trunc} << {off, 3'b000};
  assign data0     = data_full[63:0];
  assign reject    = !legal;
`else
  // Any mask byte spilling into the next word means the store crosses.
  assign data0  = trunc << {off, 3'b000};
  assign reject = !legal || (span[15:8] != 8'h00);
`endif

  // ---------------------------------------------------------------------------
  // FSM next state and pulses
  // ---------------------------------------------------------------------------
  logic done_d;
  logic err_d;
  logic load_b0;

  always_comb begin
    state_d = state;
    done_d  = 1'b0;
    err_d   = 1'b0;
    load_b0 = 1'b0;
`ifdef MISALIGN_SPLIT_EN
    load_b1 = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (reject) begin
            err_d = 1'b1;
          end else begin
            state_d = S_BEAT0;
            load_b0 = 1'b1;
          end
        end
      end
      S_BEAT0: begin
        if (mem_ack) begin
`ifdef MISALIGN_SPLIT_EN
          if (b1_pend) begin
            state_d = S_BEAT1;
            load_b1 = 1'b1;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
`else
          state_d = S_IDLE;
          done_d  = 1'b1;
`endif
        end
      end
`ifdef MISALIGN_SPLIT_EN
      S_BEAT1: begin
        if (mem_ack) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      mem_addr  <= '0;
      mem_wdata <= 64'h0;
      mem_wmask <= 8'h00;
      st_done   <= 1'b0;
      st_err    <= 1'b0;
`ifdef MISALIGN_SPLIT_EN
      b1_addr   <= '0;
      b1_wdata  <= 64'h0;
      b1_wmask  <= 8'h00;
      b1_pend   <= 1'b0;
`endif
    end else begin
      state   <= state_d;
      st_done <= done_d;
      st_err  <= err_d;
      if (load_b0) begin
        mem_addr  <= base;
        mem_wdata <= data0;
        mem_wmask <= mask0;
`ifdef MISALIGN_SPLIT_EN
        // Second beat is fully precomputed at accept; address wraps naturally.
        b1_addr   <= base + ADDR_W'(8);
        b1_wdata  <= data_full[127:64];
        b1_wmask  <= span[15:8];
        b1_pend   <= (span[15:8] != 8'h00);
`endif
      end
`ifdef MISALIGN_SPLIT_EN
      else if (load_b1) begin
        mem_addr  <= b1_addr;
        mem_wdata <= b1_wdata;
        mem_wmask <= b1_wmask;
        b1_pend   <= 1'b0;
      end
`endif
      else if (done_d) begin
        mem_addr  <= '0;
        mem_wdata <= 64'h0;
        mem_wmask <= 8'h00;
      end
    end
  end

  assign mem_wen   = (state != S_IDLE);
  assign st_ready  = (state == S_IDLE);
  assign dbg_state = state;

endmodule
